// File: rtl/inner_product_pkg.sv
// ---------------------------------------------------------------------------
// inner_product_pkg
// Shared types and helpers for the streaming inner-product engine.
//   state_t : engine FSM states (ACCUM while summing a vector, DONE while a
//             completed result waits to be accepted)
//   cnt_w() : width of the element counter for a given vector length
// ---------------------------------------------------------------------------
package inner_product_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    // Width needed to count 0..n-1; a single-element vector still gets one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/operand_fifo.sv
// ---------------------------------------------------------------------------
// operand_fifo
// Synchronous single-clock FIFO holding one operand stream.
// Parameters: DATA_W (entry width), FIFO_DEPTH (entries, power of two, >= 2)
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-low reset (empties the FIFO)
//   push  : write din this edge (never asserted while full)
//   din   : data to write
//   pop   : drop the head entry this edge (never asserted while empty)
//   head  : oldest entry, valid while !empty
//   full  : no free entries
//   empty : no entries
// Push and pop in the same edge are allowed; occupancy is then unchanged.
// ---------------------------------------------------------------------------
module operand_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push) wr_d = wr_q + (AW+1)'(1);
        if (pop)  rd_d = rd_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage is not reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= din;
    end

    assign head  = mem_q[rd_q[AW-1:0]];
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/inner_product_n.sv
// ---------------------------------------------------------------------------
// inner_product_n
// Streaming inner-product engine. Two operand streams are buffered in their
// own FIFOs; aligned pairs are multiplied and summed over VEC_LEN elements
// and each completed dot product is offered on a ready/valid output.
// Parameters: DATA_W, ACC_W, VEC_LEN (>= 1), FIFO_DEPTH (power of two, >= 2)
// Ports:
//   clk              : clock, rising edge
//   rst              : synchronous active-low reset
//   u_in/u_valid     : u operand stream in;  u_ready : u FIFO can accept
//   v_in/v_valid     : v operand stream in;  v_ready : v FIFO can accept
//   c/c_valid        : completed dot product; c_ready : consumer accepts c
// Build option: define INNER_PRODUCT_SAT_EN to clamp products and partial
// sums at 2^ACC_W-1 instead of wrapping modulo 2^ACC_W.
// ---------------------------------------------------------------------------
module inner_product_n
    import inner_product_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ACC_W      = 32,
    parameter int VEC_LEN    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] u_in,
    input  logic              u_valid,
    output logic              u_ready,
    input  logic [DATA_W-1:0] v_in,
    input  logic              v_valid,
    output logic              v_ready,
    output logic [ACC_W-1:0]  c,
    output logic              c_valid,
    input  logic              c_ready
);
    localparam int CNT_W = cnt_w(VEC_LEN);
    // Wide enough for the full product and for a saturation compare.
    localparam int WW    = ((2*DATA_W > ACC_W) ? 2*DATA_W : ACC_W) + 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(VEC_LEN - 1);
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    // Full-precision product reduced to the accumulator width.
    function automatic logic [ACC_W-1:0] mul_fit(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
`ifdef INNER_PRODUCT_SAT_EN
        logic [WW-1:0] p;
        p = WW'(a) * WW'(b);
        return (p > WW'(ACC_MAX)) ? ACC_MAX : p[ACC_W-1:0];
`else
        return ACC_W'(WW'(a) * WW'(b));
`endif
    endfunction

    // Accumulate; once clamped at ACC_MAX any further sum stays clamped.
    function automatic logic [ACC_W-1:0] add_fit(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
`ifdef INNER_PRODUCT_SAT_EN
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_W] ? ACC_MAX : s[ACC_W-1:0];
`else
        return a + b;
`endif
    endfunction

    logic [DATA_W-1:0] u_head, v_head;
    logic              u_full, u_empty, v_full, v_empty;
    logic              u_push, v_push, pop;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  c_q, c_d;
    logic              c_valid_q, c_valid_d;
    logic [ACC_W-1:0]  sum;

    assign u_ready = !u_full && rst;
    assign v_ready = !v_full && rst;
    assign u_push  = u_valid && u_ready;
    assign v_push  = v_valid && v_ready;

    // A held result blocks pops until the consumer takes it; the pop that
    // coincides with acceptance starts the next vector without a bubble.
    assign pop = !u_empty && !v_empty && (state_q == ACCUM || c_ready);

    operand_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (u_push),
        .din   (u_in),
        .pop   (pop),
        .head  (u_head),
        .full  (u_full),
        .empty (u_empty)
    );

    operand_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) v_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (v_push),
        .din   (v_in),
        .pop   (pop),
        .head  (v_head),
        .full  (v_full),
        .empty (v_empty)
    );

    // acc_q is already zero in DONE, so the same sum serves a vector's first
    // element after a result as well as the middle of a vector.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        c_d       = c_q;
        c_valid_d = c_valid_q;
        sum       = add_fit(acc_q, mul_fit(u_head, v_head));

        if (state_q == DONE && c_ready) begin
            state_d   = ACCUM;
            c_valid_d = 1'b0;
        end

        if (pop) begin
            if (cnt_q == LAST) begin
                c_d       = sum;
                c_valid_d = 1'b1;
                acc_d     = '0;
                cnt_d     = '0;
                state_d   = DONE;
            end else begin
                acc_d     = sum;
                cnt_d     = cnt_q + CNT_W'(1);
                state_d   = ACCUM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ACCUM;
            cnt_q     <= '0;
            acc_q     <= '0;
            c_q       <= '0;
            c_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            c_q       <= c_d;
            c_valid_q <= c_valid_d;
        end
    end

    assign c       = c_q;
    assign c_valid = c_valid_q;

endmodule
